// File: rtl/unary_add_pkg.sv
// Shared types and default sizing for the unary-add scheduler.
package unary_add_pkg;

   localparam int unsigned MOD_DEF    = 14;
   localparam int unsigned RD_LEN_DEF = 16;
   localparam int unsigned NREQ_DEF   = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the lowest requesting index at or after ptr wins.
// Ports:
//   req  in  N   request vector
//   ptr  in  IW  search start index
//   gnt  out N   one-hot grant (combinational)
//   idx  out IW  index of the winner (combinational)
//   any  out 1   at least one request present (combinational)
module rr_arbiter #(
   parameter int unsigned N  = 2,
   parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW-1:0] k;

   // Walk the requesters in rotated order; first hit wins.
   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      k   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         k = IW'((32'(ptr) + i) % N);
         if (!any && req[k]) begin
            any    = 1'b1;
            idx    = k;
            gnt[k] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/unary_add_sched.sv
// Time-shares one unary-add core between NREQ requesters. Each transaction
// drives the core through RD_LEN read cycles, then drains it in write mode,
// counting carry pulses and dout ones for the winning requester.
// Optional feature macro: UNARY_SCHED_EARLY_EXIT_EN (leave WRITE as soon as
// the drained core reports dout==0).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req/a_in/b_in [NREQ]  per-requester request level and serial A/B streams
//   gnt [NREQ]            one-hot owner, held READ..DONE
//   rd_strobe             granted a_in/b_in consumed this cycle
//   done                  one-cycle result-valid pulse
//   res_sum, res_carry    residue and carry count of the last transaction
//   core_en/rw/a/b        core control; core_a/core_b are gated pass-through
//   core_c, core_dout     core outputs (one-cycle latency)
module unary_add_sched
   import unary_add_pkg::*;
#(
   parameter int unsigned MOD    = MOD_DEF,
   parameter int unsigned RD_LEN = RD_LEN_DEF,
   parameter int unsigned NREQ   = NREQ_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NREQ-1:0]            req,
   input  logic [NREQ-1:0]            a_in,
   input  logic [NREQ-1:0]            b_in,
   output logic [NREQ-1:0]            gnt,
   output logic                       rd_strobe,
   output logic                       done,
   output logic [$clog2(MOD)-1:0]     res_sum,
   output logic [$clog2(RD_LEN+1)-1:0] res_carry,
   output logic                       core_en,
   output logic                       core_rw,
   output logic                       core_a,
   output logic                       core_b,
   input  logic                       core_c,
   input  logic                       core_dout
);

   localparam int unsigned SW     = $clog2(MOD);
   localparam int unsigned CYW    = $clog2(RD_LEN + 1);
   localparam int unsigned PH_MAX = (RD_LEN > MOD) ? RD_LEN : MOD;
   localparam int unsigned PW     = $clog2(PH_MAX);
   localparam int unsigned IW     = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_e              state_q, state_d;
   logic [PW-1:0]       phase_q, phase_d;
   logic [IW-1:0]       win_q, win_d;
   logic [IW-1:0]       ptr_q, ptr_d;
   logic [NREQ-1:0]     gnt_d;
   logic [SW-1:0]       sum_d;
   logic [CYW-1:0]      carry_d;
   logic [NREQ-1:0]     arb_gnt;
   logic [IW-1:0]       arb_idx;
   logic                arb_any;

   rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
      .req (req),
      .ptr (ptr_q),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   // Only the granted stream reaches the core, and only while reading.
   assign core_a = rd_strobe & |(gnt & a_in);
   assign core_b = rd_strobe & |(gnt & b_in);

   // Next-state, phase counter and accumulators.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      win_d   = win_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt;
      sum_d   = res_sum;
      carry_d = res_carry;
      case (state_q)
         IDLE: begin
            gnt_d = '0;
            if (arb_any) begin
               state_d = READ;
               phase_d = '0;
               win_d   = arb_idx;
               gnt_d   = arb_gnt;
               sum_d   = '0;
               carry_d = '0;
            end
         end
         READ: begin
            // core_c lags one cycle, so r=0 still shows the idle core.
            if (phase_q != '0 && core_c) carry_d = res_carry + CYW'(1);
            if (phase_q == PW'(RD_LEN - 1)) begin
               state_d = WRITE;
               phase_d = '0;
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end
         WRITE: begin
            // w=0 still carries the last read cycle's C; dout lags one cycle.
            if (phase_q == '0) begin
               if (core_c) carry_d = res_carry + CYW'(1);
            end else if (core_dout) begin
               sum_d = res_sum + SW'(1);
            end
`ifdef UNARY_SCHED_EARLY_EXIT_EN
            if ((phase_q != '0 && !core_dout) || phase_q == PW'(MOD - 1)) begin
               state_d = DONE;
            end else begin
               phase_d = phase_q + PW'(1);
            end
`else
            if (phase_q == PW'(MOD - 1)) begin
               state_d = DONE;
            end else begin
               phase_d = phase_q + PW'(1);
            end
`endif
         end
         DONE: begin
            state_d = IDLE;
            gnt_d   = '0;
            ptr_d   = (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs, decoded from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         phase_q   <= '0;
         win_q     <= '0;
         ptr_q     <= '0;
         gnt       <= '0;
         res_sum   <= '0;
         res_carry <= '0;
         done      <= 1'b0;
         rd_strobe <= 1'b0;
         core_en   <= 1'b0;
         core_rw   <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         win_q     <= win_d;
         ptr_q     <= ptr_d;
         gnt       <= gnt_d;
         res_sum   <= sum_d;
         res_carry <= carry_d;
         done      <= (state_d == DONE);
         rd_strobe <= (state_d == READ);
         core_en   <= (state_d == READ) || (state_d == WRITE);
         core_rw   <= (state_d == WRITE);
      end
   end

endmodule

// File: tb/tb_unary_add_sched.sv
// Directed bench for unary_add_sched with a behavioural mod-MOD unary-add core.
module tb_unary_add_sched;

   localparam int MOD    = 14;
   localparam int RD_LEN = 16;
   localparam int NREQ   = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [NREQ-1:0] req = '0;
   logic [NREQ-1:0] a_in = '0;
   logic [NREQ-1:0] b_in = '0;
   logic [NREQ-1:0] gnt;
   logic            rd_strobe, done;
   logic [3:0]      res_sum;
   logic [4:0]      res_carry;
   logic            core_en, core_rw, core_a, core_b;
   logic            core_c, core_dout;

   int n_total = 0;
   int n_bad   = 0;

   unary_add_sched #(.MOD(MOD), .RD_LEN(RD_LEN), .NREQ(NREQ)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .a_in      (a_in),
      .b_in      (b_in),
      .gnt       (gnt),
      .rd_strobe (rd_strobe),
      .done      (done),
      .res_sum   (res_sum),
      .res_carry (res_carry),
      .core_en   (core_en),
      .core_rw   (core_rw),
      .core_a    (core_a),
      .core_b    (core_b),
      .core_c    (core_c),
      .core_dout (core_dout)
   );

   always #5 clk = ~clk;

   // Core model: read adds A+B mod MOD (C on wrap); write drains one unit per cycle.
   int core_cnt;
   always @(posedge clk or negedge rst_n) begin : core_model
      int s;
      if (!rst_n) begin
         core_cnt  <= 0;
         core_c    <= 1'b0;
         core_dout <= 1'b0;
      end else if (core_en) begin
         if (!core_rw) begin
            s = core_cnt + int'(core_a) + int'(core_b);
            core_c    <= (s >= MOD);
            core_cnt  <= (s >= MOD) ? s - MOD : s;
            core_dout <= 1'b0;
         end else begin
            core_c    <= 1'b0;
            core_dout <= (core_cnt != 0);
            if (core_cnt != 0) core_cnt <= core_cnt - 1;
         end
      end
   end

   task automatic check(input string tag, input int got, input int exp);
      n_total++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int exp_lat(input int sum);
`ifdef UNARY_SCHED_EARLY_EXIT_EN
      return (RD_LEN + sum + 3 < RD_LEN + MOD + 1) ? RD_LEN + sum + 3 : RD_LEN + MOD + 1;
`else
      return RD_LEN + MOD + 1 + 0 * sum;
`endif
   endfunction

   // One transaction for requester idx; call #1 after a posedge while IDLE.
   task automatic run_txn(input string tag, input int idx, input logic [15:0] ap,
                          input logic [15:0] bp, input int e_sum, input int e_carry);
      int   cyc;
      int   r;
      logic got_done;
      cyc = 0; r = 0; got_done = 1'b0;
      req[idx] = 1'b1;
      while (!got_done && cyc < 100) begin
         @(posedge clk); #1; cyc++;
         if (rd_strobe) begin
            if (r == 0) begin
               check({tag, "_gnt"}, int'(gnt), 1 << idx);
               req[idx] = 1'b0;
            end
            a_in[idx] = ap[r[3:0]];
            b_in[idx] = bp[r[3:0]];
            r++;
         end else begin
            // Ungranted-phase junk must not reach the core.
            a_in = '1;
            b_in = '1;
         end
         if (cyc == RD_LEN + 1)
            check({tag, "_wr_pins"}, int'({core_en, core_rw, core_a | core_b}), 6);
         if (done) got_done = 1'b1;
      end
      a_in = '0;
      b_in = '0;
      check({tag, "_lat"}, cyc, exp_lat(e_sum));
      check({tag, "_sum"}, int'(res_sum), e_sum);
      check({tag, "_carry"}, int'(res_carry), e_carry);
      check({tag, "_gnt_done"}, int'(gnt), 1 << idx);
      @(posedge clk); #1;
      check({tag, "_after"}, int'({done, gnt}), 0);
   endtask

   int   c;
   int   r;
   logic both;

   initial begin
      // Reset values.
      #2;
      check("rst_gnt", int'(gnt), 0);
      check("rst_ctl", int'({done, rd_strobe, core_en, core_rw, core_a, core_b}), 0);
      check("rst_res", int'({res_sum, res_carry}), 0);
      #20 rst_n = 1'b1;
      @(posedge clk); #1;

      // 32 units -> residue 4, two carries.
      run_txn("t1", 0, 16'hFFFF, 16'hFFFF, 4, 2);
      // Exactly one wrap; req dropped mid-transaction on requester 1.
      run_txn("t2", 1, 16'h3FFF, 16'h0000, 0, 1);

      // Both requesting from reset: 0, 1, 0, never both granted.
      rst_n = 1'b0; #3 rst_n = 1'b1;
      @(posedge clk); #1;
      req = 2'b11;
      both = 1'b0;
      for (int k = 0; k < 3; k++) begin
         c = 0;
         while (!done && c < 100) begin
            @(posedge clk); #1; c++;
            if (gnt == 2'b11) both = 1'b1;
         end
         check($sformatf("arb_%0d", k), int'(gnt), (k == 1) ? 2 : 1);
         @(posedge clk); #1;
      end
      req = '0;
      check("arb_onehot", int'(both), 0);
      @(posedge clk); #1;

      // Reset during READ r=5, then a clean transaction.
      req[0] = 1'b1;
      c = 0; r = 0;
      while (r < 6 && c < 50) begin
         @(posedge clk); #1; c++;
         if (rd_strobe) begin
            a_in = '1; b_in = '1; req = '0; r++;
         end
      end
      check("rst_mid_reached", r, 6);
      rst_n = 1'b0; #1;
      check("rst_mid_ctl", int'({gnt, core_en, done, rd_strobe}), 0);
      a_in = '0; b_in = '0;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      run_txn("t5", 0, 16'h0007, 16'h0000, 3, 0);

      // Empty transactions back to back, residue boundary, then clean restart.
      run_txn("t6a", 0, 16'h0000, 16'h0000, 0, 0);
      run_txn("t6b", 0, 16'h0000, 16'h0000, 0, 0);
      run_txn("t6max", 0, 16'h1FFF, 16'h0000, 13, 0);
      run_txn("t6c", 0, 16'hFFFF, 16'hFFFF, 4, 2);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
